// File: rtl/game_timer_sched_pkg.sv
// Shared types and helpers for the game delay-timer scheduler.
package game_timer_pkg;

  typedef enum logic [1:0] {IDLE, ARB, RUN, DONE} state_t;

  localparam logic [1:0] LEN_HALF = 2'd0;
  localparam logic [1:0] LEN_1S   = 2'd1;
  localparam logic [1:0] LEN_2S   = 2'd2;
  localparam logic [1:0] LEN_4S   = 2'd3;

  // Delay length in timer ticks for a 2-bit select code
  function automatic int unsigned len_ticks(input logic [1:0] sel, input int unsigned tick_hz);
    case (sel)
      LEN_HALF: return tick_hz / 2;
      LEN_1S:   return tick_hz;
      LEN_2S:   return 2 * tick_hz;
      default:  return 4 * tick_hz;
    endcase
  endfunction

  function automatic int unsigned cnt_width(input int unsigned tick_hz);
    return 32'($clog2(4 * tick_hz + 1));
  endfunction

endpackage

// File: rtl/game_timer_sched_rr_arbiter.sv
// N-way one-hot arbiter; round-robin by default, fixed lowest-index priority
// when SCHED_STRICT_PRIO_EN is defined.
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic         clk_50M,
  input  logic         i_Reset,
  input  logic [N-1:0] req,
  input  logic         adv,
  input  logic [N-1:0] owner,
  output logic [N-1:0] grant_c
);

`ifdef SCHED_STRICT_PRIO_EN

  logic found;
  logic unused_ok;

  assign unused_ok = ^{clk_50M, i_Reset, adv, owner};

  always_comb begin
    grant_c = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        grant_c[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

`else

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] own_idx;
  logic             found;

  // Scan requesters starting at the pointer, wrapping around
  always_comb begin
    grant_c = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IDX_W'((32'(ptr) + i) % N);
      if (!found && req[idx]) begin
        grant_c[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  always_comb begin
    own_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (owner[i]) own_idx = IDX_W'(i);
    end
  end

  // Pointer moves to the requester after the one just served
  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (own_idx == IDX_W'(N - 1)) ? '0 : own_idx + IDX_W'(1);
    end
  end

`endif

endmodule

// File: rtl/game_timer_sched.sv
// Shares the BlackJack game delay timer between N_REQ requesters.
// Build option: SCHED_STRICT_PRIO_EN selects fixed priority instead of round-robin.
module game_timer_sched
  import game_timer_pkg::*;
#(
  parameter  int unsigned N_REQ   = 3,
  parameter  int unsigned CLK_HZ  = 50000000,
  parameter  int unsigned TICK_HZ = 2000,
  localparam int unsigned PRE_DIV = CLK_HZ / TICK_HZ,
  localparam int unsigned PRE_W   = $clog2(PRE_DIV),
  localparam int unsigned CNT_W   = cnt_width(TICK_HZ)
) (
  input  logic               clk_50M,
  input  logic               i_Reset,
  input  logic [N_REQ-1:0]   i_Req,
  input  logic [2*N_REQ-1:0] i_Len,
  input  logic               i_Abort,
  output logic [N_REQ-1:0]   o_Grant,
  output logic [N_REQ-1:0]   o_Done,
  output logic               o_Busy,
  output logic [CNT_W-1:0]   o_Count,
  output logic               o_Tick
);

  state_t           state;
  logic [PRE_W-1:0] pre;
  logic [N_REQ-1:0] grant_c;
  logic [1:0]       arb_len;
  logic             adv;
  logic             cancel;
  logic             wrap;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk_50M (clk_50M),
    .i_Reset (i_Reset),
    .req     (i_Req),
    .adv     (adv),
    .owner   (o_Grant),
    .grant_c (grant_c)
  );

  always_comb begin
    arb_len = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_c[i]) arb_len = i_Len[2*i +: 2];
    end
  end

  assign cancel = i_Abort || !(|(i_Req & o_Grant));
  assign wrap   = (pre == PRE_W'(PRE_DIV - 1));
  assign adv    = (state == DONE) || ((state == RUN) && cancel);

  // Cancel is checked before the tick so it wins over a coinciding final tick
  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      state   <= IDLE;
      pre     <= '0;
      o_Grant <= '0;
      o_Done  <= '0;
      o_Busy  <= 1'b0;
      o_Count <= '0;
      o_Tick  <= 1'b0;
    end else begin
      o_Done <= '0;
      o_Tick <= 1'b0;
      case (state)
        IDLE: begin
          if (|i_Req) begin
            state  <= ARB;
            o_Busy <= 1'b1;
          end
        end
        ARB: begin
          pre <= '0;
          if (|i_Req) begin
            state   <= RUN;
            o_Grant <= grant_c;
            o_Count <= CNT_W'(len_ticks(arb_len, TICK_HZ));
          end else begin
            state  <= IDLE;
            o_Busy <= 1'b0;
          end
        end
        RUN: begin
          if (cancel) begin
            state   <= IDLE;
            pre     <= '0;
            o_Grant <= '0;
            o_Count <= '0;
            o_Busy  <= 1'b0;
          end else if (wrap) begin
            pre <= '0;
            if (o_Count == CNT_W'(1)) begin
              state   <= DONE;
              o_Done  <= o_Grant;
              o_Count <= '0;
              o_Busy  <= 1'b0;
            end else begin
              o_Count <= o_Count - CNT_W'(1);
            end
          end else begin
            pre    <= pre + PRE_W'(1);
            o_Tick <= (pre == PRE_W'(PRE_DIV - 2));
          end
        end
        DONE: begin
          state   <= IDLE;
          o_Grant <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_timer_sched.sv
// Directed bench for game_timer_sched at CLK_HZ=20, TICK_HZ=2 (PRE_DIV=10).
module tb_game_timer_sched;

  localparam int unsigned N_REQ   = 3;
  localparam int unsigned CLK_HZ  = 20;
  localparam int unsigned TICK_HZ = 2;
  localparam int unsigned CNT_W   = 4;

  logic               clk_50M = 1'b0;
  logic               i_Reset;
  logic [N_REQ-1:0]   i_Req;
  logic [2*N_REQ-1:0] i_Len;
  logic               i_Abort;
  logic [N_REQ-1:0]   o_Grant;
  logic [N_REQ-1:0]   o_Done;
  logic               o_Busy;
  logic [CNT_W-1:0]   o_Count;
  logic               o_Tick;

  int tests = 0;
  int fails = 0;

  always #5 clk_50M = ~clk_50M;

  game_timer_sched #(.N_REQ(N_REQ), .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .clk_50M (clk_50M),
    .i_Reset (i_Reset),
    .i_Req   (i_Req),
    .i_Len   (i_Len),
    .i_Abort (i_Abort),
    .o_Grant (o_Grant),
    .o_Done  (o_Done),
    .o_Busy  (o_Busy),
    .o_Count (o_Count),
    .o_Tick  (o_Tick)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_50M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    i_Reset = 1'b1;
    i_Req   = '0;
    i_Abort = 1'b0;
    i_Len   = '0;
    cyc(1);
    i_Reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] order [4];
`ifdef SCHED_STRICT_PRIO_EN
    order = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
    order = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif

    // Reset state
    i_Reset = 1'b1; i_Req = 3'b111; i_Len = 6'b111111; i_Abort = 1'b0;
    cyc(2);
    chk("rst_grant", 32'(o_Grant), 0);
    chk("rst_done",  32'(o_Done), 0);
    chk("rst_count", 32'(o_Count), 0);
    chk("rst_busy",  32'(o_Busy), 0);
    chk("rst_tick",  32'(o_Tick), 0);
    i_Reset = 1'b0; i_Req = '0; i_Len = '0;

    // Single request, 4-tick delay
    i_Req = 3'b001; i_Len = 6'b000010;
    cyc(1);
    chk("s_arb_busy",  32'(o_Busy), 1);
    chk("s_arb_grant", 32'(o_Grant), 0);
    cyc(1);
    chk("s_grant", 32'(o_Grant), 32'b001);
    chk("s_cnt4",  32'(o_Count), 4);
    cyc(9);
    chk("s_tick",     32'(o_Tick), 1);
    chk("s_cnt4b",    32'(o_Count), 4);
    cyc(1);
    chk("s_cnt3",     32'(o_Count), 3);
    chk("s_tick_off", 32'(o_Tick), 0);
    cyc(10); chk("s_cnt2", 32'(o_Count), 2);
    cyc(10); chk("s_cnt1", 32'(o_Count), 1);
    cyc(9);  chk("s_nodone_39", 32'(o_Done), 0);
    cyc(1);
    chk("s_done_40",  32'(o_Done), 32'b001);
    chk("s_cnt0",     32'(o_Count), 0);
    chk("s_busy_done", 32'(o_Busy), 0);
    i_Req = '0;
    cyc(1);
    chk("s_done_1cyc", 32'(o_Done), 0);
    chk("s_grant_clr", 32'(o_Grant), 0);

    // Request dropped while in ARB: back to idle, prescaler stays quiet
    i_Req = 3'b001;
    cyc(1);
    i_Req = '0;
    cyc(1);
    chk("a_grant", 32'(o_Grant), 0);
    chk("a_busy",  32'(o_Busy), 0);
    cyc(3);
    chk("a_tick_idle", 32'(o_Tick), 0);
    chk("a_cnt_idle",  32'(o_Count), 0);

    // Contention, all 1-tick delays
    do_reset();
    i_Req = 3'b111; i_Len = '0;
    cyc(2);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("c_grant%0d", k), 32'(o_Grant), 32'(order[k]));
      chk($sformatf("c_cnt%0d", k), 32'(o_Count), 1);
      cyc(9);
      chk($sformatf("c_nodone%0d", k), 32'(o_Done), 0);
      cyc(1);
      chk($sformatf("c_done%0d", k), 32'(o_Done), 32'(order[k]));
      if (k == 3) i_Req = '0;
      cyc(1);
      chk($sformatf("c_gap%0d", k), 32'(o_Grant), 0);
      if (k < 3) cyc(2);
    end
    chk("c_idle_busy", 32'(o_Busy), 0);

    // Owner drops at RUN cycle 15; pending requester 1 is served next
    do_reset();
    i_Req = 3'b011; i_Len = 6'b000110;
    cyc(2);
    chk("d_grant0", 32'(o_Grant), 32'b001);
    chk("d_cnt4",   32'(o_Count), 4);
    cyc(15);
    chk("d_cnt3", 32'(o_Count), 3);
    i_Req = 3'b010;
    cyc(1);
    chk("d_grant_clr", 32'(o_Grant), 0);
    chk("d_cnt_clr",   32'(o_Count), 0);
    chk("d_nodone",    32'(o_Done), 0);
    cyc(2);
    chk("d_grant1", 32'(o_Grant), 32'b010);
    chk("d_cnt2",   32'(o_Count), 2);
    cyc(19); chk("d_nodone1", 32'(o_Done), 0);
    cyc(1);  chk("d_done1",   32'(o_Done), 32'b010);
    i_Req = '0;
    cyc(1);

    // Abort on the final tick wins over completion
    do_reset();
    i_Req = 3'b001; i_Len = '0;
    cyc(2);
    chk("ab_grant", 32'(o_Grant), 32'b001);
    cyc(9);
    chk("ab_tick", 32'(o_Tick), 1);
    chk("ab_cnt1", 32'(o_Count), 1);
    i_Abort = 1'b1;
    cyc(1);
    chk("ab_nodone", 32'(o_Done), 0);
    chk("ab_grant0", 32'(o_Grant), 0);
    chk("ab_cnt0",   32'(o_Count), 0);
    chk("ab_busy0",  32'(o_Busy), 0);
    i_Abort = 1'b0; i_Req = '0;
    cyc(1);
    chk("ab_nodone2", 32'(o_Done), 0);

    // Reset mid-RUN, then a full-length re-run
    do_reset();
    i_Req = 3'b101; i_Len = 6'b000010;
    cyc(2);
    chk("r_grant", 32'(o_Grant), 32'b001);
    cyc(10);
    chk("r_cnt3", 32'(o_Count), 3);
    i_Reset = 1'b1;
    cyc(1);
    chk("r_grant0", 32'(o_Grant), 0);
    chk("r_cnt0",   32'(o_Count), 0);
    chk("r_busy0",  32'(o_Busy), 0);
    chk("r_done0",  32'(o_Done), 0);
    i_Reset = 1'b0;
    cyc(2);
    chk("r_regrant", 32'(o_Grant), 32'b001);
    chk("r_cnt4",    32'(o_Count), 4);
    cyc(39); chk("r_nodone", 32'(o_Done), 0);
    cyc(1);  chk("r_done",   32'(o_Done), 32'b001);
    i_Req = '0;
    cyc(1);

    // Length change during RUN is ignored
    do_reset();
    i_Req = 3'b001; i_Len = 6'b000011;
    cyc(2);
    chk("l_cnt8", 32'(o_Count), 8);
    cyc(5);
    i_Len = '0;
    cyc(74);
    chk("l_nodone", 32'(o_Done), 0);
    chk("l_cnt1",   32'(o_Count), 1);
    cyc(1);
    chk("l_done", 32'(o_Done), 32'b001);
    i_Req = '0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
